// File: rtl/ysyx_22050550_axi_burst_master_pkg.sv
// Shared types and AXI constants for the cache-side burst master.
// Anything that both the FSM and the line buffer need lives here.
package ysyx_22050550_axi_burst_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_RESP
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam int         BEAT_W     = 64;

  function automatic int line_w(input int beats);
    return BEAT_W * beats;
  endfunction

endpackage

// File: rtl/ysyx_22050550_axi_burst_master_if.sv
// Memory-side AXI read/write channels (no B channel) as seen by the burst master.
interface ysyx_22050550_axi_burst_master_if;

  logic        ar_valid;
  logic        ar_ready;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;

  logic        r_valid;
  logic        r_ready;
  logic [63:0] r_data;
  logic        r_last;

  logic        aw_valid;
  logic        aw_ready;
  logic [63:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;

  logic        w_valid;
  logic        w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;

  modport master (
    output ar_valid, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_data, r_last,
    output r_ready,
    output aw_valid, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready
  );

  modport slave (
    input  ar_valid, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_data, r_last,
    input  r_ready,
    input  aw_valid, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready
  );

endinterface

// File: rtl/ysyx_22050550_axi_line_buf.sv
// BEATS x 64-bit line buffer: parallel load, clear, per-beat write and indexed beat read.
// Beat writes whose index falls outside the line are silently dropped.
module ysyx_22050550_axi_line_buf #(
  parameter int BEATS  = 2,
  parameter int LINE_W = 64 * BEATS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [LINE_W-1:0] load_data,
  input  logic              wr_en,
  input  logic [3:0]        wr_idx,
  input  logic [63:0]       wr_data,
  input  logic [3:0]        rd_idx,
  output logic [63:0]       rd_data,
  output logic [LINE_W-1:0] line
);

  logic [63:0] slot [BEATS];

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      for (int i = 0; i < BEATS; i++) slot[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < BEATS; i++) slot[i] <= load_data[64*i +: 64];
    end else if (wr_en) begin
      for (int i = 0; i < BEATS; i++) begin
        if (wr_idx == 4'(i)) slot[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (rd_idx == 4'(i)) rd_data = slot[i];
    end
  end

  for (genvar g = 0; g < BEATS; g++) begin : g_line
    assign line[64*g +: 64] = slot[g];
  end

endmodule

// File: rtl/ysyx_22050550_axi_burst_master.sv
// Turns one cache/LSU request into a single AXI INCR burst (line or single beat)
// and hands the buffered line back through a valid/ready response.
//
// state   | meaning
// IDLE    | ready for a request
// AR      | read address offered
// R       | collecting read beats into the buffer
// AW      | write address offered
// W       | streaming buffered beats out
// RESP    | response held until the requester takes it
module ysyx_22050550_axi_burst_master
  import ysyx_22050550_axi_burst_master_pkg::*;
#(
  parameter int BEATS  = 2,
  parameter int LINE_W = line_w(BEATS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic              req_line,
  input  logic [63:0]       req_addr,
  input  logic [2:0]        req_size,
  input  logic [LINE_W-1:0] req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [LINE_W-1:0] resp_rdata,
  output logic              resp_err,
  ysyx_22050550_axi_burst_master_if.master axi
);

  state_e      state;
  logic [63:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [7:0]  strb_q;
  logic [3:0]  cnt;
  logic        ovf;
  logic        ar_valid_q;
  logic        aw_valid_q;
  logic        w_valid_q;
  logic        r_ready_q;

  logic        accept;
  logic        cnt_is_len;
  logic        buf_wr_en;
  logic [63:0] buf_rd;

  assign accept     = (state == ST_IDLE) && req_valid;
  assign cnt_is_len = ({4'h0, cnt} == len_q);
  // ovf marks beats past index 15 so a late r_last can never alias a valid index
  assign buf_wr_en  = r_ready_q && axi.r_valid && !ovf;

  ysyx_22050550_axi_line_buf #(
    .BEATS  (BEATS),
    .LINE_W (LINE_W)
  ) u_line_buf (
    .clock     (clock),
    .reset     (reset),
    .clear     (accept && !req_wen),
    .load      (accept && req_wen),
    .load_data (req_wdata),
    .wr_en     (buf_wr_en),
    .wr_idx    (cnt),
    .wr_data   (axi.r_data),
    .rd_idx    (cnt),
    .rd_data   (buf_rd),
    .line      (resp_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      ar_valid_q <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      r_ready_q  <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      strb_q     <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            len_q     <= req_line ? 8'(BEATS - 1) : 8'd0;
            size_q    <= req_line ? SIZE_8B : req_size;
            strb_q    <= req_line ? 8'hFF : req_wstrb;
            cnt       <= '0;
            ovf       <= 1'b0;
            resp_err  <= 1'b0;
            req_ready <= 1'b0;
            if (req_wen) begin
              aw_valid_q <= 1'b1;
              state      <= ST_AW;
            end else begin
              ar_valid_q <= 1'b1;
              state      <= ST_AR;
            end
          end
        end
        ST_AR: begin
          if (axi.ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state      <= ST_R;
          end
        end
        ST_R: begin
          if (axi.r_valid) begin
            if (cnt != 4'hF) cnt <= cnt + 4'd1;
            else             ovf <= 1'b1;
            if (axi.r_last) begin
              r_ready_q  <= 1'b0;
              resp_valid <= 1'b1;
              resp_err   <= ovf || !cnt_is_len;
              state      <= ST_RESP;
            end
          end
        end
        ST_AW: begin
          if (axi.aw_ready) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b1;
            state      <= ST_W;
          end
        end
        ST_W: begin
          if (axi.w_ready) begin
            if (cnt_is_len) begin
              w_valid_q  <= 1'b0;
              resp_valid <= 1'b1;
              state      <= ST_RESP;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign axi.ar_valid = ar_valid_q;
  assign axi.ar_addr  = addr_q;
  assign axi.ar_len   = len_q;
  assign axi.ar_size  = size_q;
  assign axi.ar_burst = BURST_INCR;
  assign axi.r_ready  = r_ready_q;

  assign axi.aw_valid = aw_valid_q;
  assign axi.aw_addr  = addr_q;
  assign axi.aw_len   = len_q;
  assign axi.aw_size  = size_q;
  assign axi.aw_burst = BURST_INCR;

  // W payload is forced to zero outside the W phase so idle outputs stay quiet
  assign axi.w_valid  = w_valid_q;
  assign axi.w_data   = w_valid_q ? buf_rd : '0;
  assign axi.w_strb   = w_valid_q ? strb_q : '0;
  assign axi.w_last   = w_valid_q && cnt_is_len;

endmodule

// File: tb/tb_ysyx_22050550_axi_burst_master.sv
// Scenario bench for the burst master: bench-driven AXI responder, expected lines and
// W beats queued when a request is issued and popped when the DUT produces them.
module tb_ysyx_22050550_axi_burst_master;

  localparam int LINE_W = 128;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic              req_line;
  logic [63:0]       req_addr;
  logic [2:0]        req_size;
  logic [LINE_W-1:0] req_wdata;
  logic [7:0]        req_wstrb;
  logic              resp_valid;
  logic              resp_ready;
  logic [LINE_W-1:0] resp_rdata;
  logic              resp_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [LINE_W-1:0] exp_rd_q [$];
  logic              exp_err_q[$];
  logic [72:0]       exp_w_q  [$];

  ysyx_22050550_axi_burst_master_if axi ();

  ysyx_22050550_axi_burst_master #(.BEATS(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_line   (req_line),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .axi        (axi)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_req(input logic wen, input logic line, input logic [63:0] addr,
                          input logic [2:0] size, input logic [LINE_W-1:0] wdata,
                          input logic [7:0] wstrb);
    req_wen   = wen;
    req_line  = line;
    req_addr  = addr;
    req_size  = size;
    req_wdata = wdata;
    req_wstrb = wstrb;
    req_valid = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (req_ready !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout req_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready);
    end
    n_cmp++;
    if ({axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, resp_valid, resp_err, axi.w_last} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_valids got %b want 0000000",
               {axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, resp_valid, resp_err, axi.w_last});
    end
    n_cmp++;
    if ({axi.ar_addr, axi.aw_addr, axi.w_data, axi.w_strb} !== 200'h0) begin
      n_err++; $display("FAIL reset_data ar_addr %h aw_addr %h w_data %h w_strb %h want 0",
                        axi.ar_addr, axi.aw_addr, axi.w_data, axi.w_strb);
    end
    n_cmp++;
    if (resp_rdata !== '0) begin
      n_err++; $display("FAIL reset_rdata got %h want 0", resp_rdata);
    end
    n_cmp++;
    if ({axi.ar_burst, axi.aw_burst} !== 4'b0101) begin
      n_err++; $display("FAIL reset_burst got %b want 0101", {axi.ar_burst, axi.aw_burst});
    end
  endtask

  task automatic test_line_read();
    logic [LINE_W-1:0] e;
    logic ee;
    exp_rd_q.push_back({64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    exp_err_q.push_back(1'b0);
    send_req(1'b0, 1'b1, 64'h8000_0010, 3'd0, '0, 8'h00);
    n_cmp++;
    if ({axi.ar_valid, axi.ar_addr, axi.ar_len, axi.ar_size, axi.ar_burst} !==
        {1'b1, 64'h8000_0010, 8'd1, 3'd3, 2'b01}) begin
      n_err++; $display("FAIL line_read_ar got v%b a%h l%0d s%0d b%0d want v1 a8000_0010 l1 s3 b1",
                        axi.ar_valid, axi.ar_addr, axi.ar_len, axi.ar_size, axi.ar_burst);
    end
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_err++; $display("FAIL line_read_busy req_ready got %b want 0", req_ready);
    end
    @(negedge clock);
    n_cmp++;
    if (axi.r_ready !== 1'b1) begin
      n_err++; $display("FAIL line_read_rready got %b want 1", axi.r_ready);
    end
    axi.r_valid = 1'b1; axi.r_data = 64'h1111_1111_1111_1111; axi.r_last = 1'b0;
    @(negedge clock);
    axi.r_data = 64'h2222_2222_2222_2222; axi.r_last = 1'b1;
    @(negedge clock);
    axi.r_valid = 1'b0; axi.r_last = 1'b0;
    e = exp_rd_q.pop_front(); ee = exp_err_q.pop_front();
    n_cmp++;
    if ({resp_valid, resp_rdata, resp_err} !== {1'b1, e, ee}) begin
      n_err++; $display("FAIL line_read_resp got v%b d%h e%b want v1 d%h e%b",
                        resp_valid, resp_rdata, resp_err, e, ee);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    n_cmp++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      n_err++; $display("FAIL line_read_release got %b want 10", {req_ready, resp_valid});
    end
    wait_idle();
  endtask

  task automatic test_single_write();
    logic [72:0] e;
    exp_w_q.push_back({64'h5A, 8'h01, 1'b1});
    send_req(1'b1, 1'b0, 64'ha000_03f8, 3'd0, 128'h5A, 8'h01);
    n_cmp++;
    if ({axi.aw_valid, axi.aw_addr, axi.aw_len, axi.aw_size, axi.aw_burst, axi.ar_valid} !==
        {1'b1, 64'ha000_03f8, 8'd0, 3'd0, 2'b01, 1'b0}) begin
      n_err++; $display("FAIL single_write_aw got v%b a%h l%0d s%0d b%0d arv%b want v1 aa000_03f8 l0 s0 b1 arv0",
                        axi.aw_valid, axi.aw_addr, axi.aw_len, axi.aw_size, axi.aw_burst, axi.ar_valid);
    end
    @(negedge clock);
    axi.w_ready = 1'b1;
    e = exp_w_q.pop_front();
    n_cmp++;
    if ({axi.w_valid, axi.w_data, axi.w_strb, axi.w_last} !== {1'b1, e}) begin
      n_err++; $display("FAIL single_write_w got v%b d%h s%h l%b want v1 %h",
                        axi.w_valid, axi.w_data, axi.w_strb, axi.w_last, e);
    end
    @(negedge clock);
    axi.w_ready = 1'b0;
    n_cmp++;
    if ({axi.w_valid, resp_valid, resp_err} !== 3'b010) begin
      n_err++; $display("FAIL single_write_resp got %b want 010", {axi.w_valid, resp_valid, resp_err});
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    wait_idle();
  endtask

  task automatic test_line_write_stall();
    logic [72:0] e;
    exp_w_q.push_back({64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 1'b0});
    exp_w_q.push_back({64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, 1'b1});
    send_req(1'b1, 1'b1, 64'h8000_1000, 3'd1,
             {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 8'h0F);
    n_cmp++;
    if ({axi.aw_valid, axi.aw_len, axi.aw_size} !== {1'b1, 8'd1, 3'd3}) begin
      n_err++; $display("FAIL line_write_aw got v%b l%0d s%0d want v1 l1 s3",
                        axi.aw_valid, axi.aw_len, axi.aw_size);
    end
    @(negedge clock);
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 3; s++) begin
        n_cmp++;
        if ({axi.w_valid, axi.w_data, axi.w_strb, axi.w_last} !== {1'b1, exp_w_q[0]}) begin
          n_err++; $display("FAIL line_write_stall b%0d s%0d got v%b d%h s%h l%b want v1 %h",
                            b, s, axi.w_valid, axi.w_data, axi.w_strb, axi.w_last, exp_w_q[0]);
        end
        @(negedge clock);
      end
      axi.w_ready = 1'b1;
      e = exp_w_q.pop_front();
      n_cmp++;
      if ({axi.w_valid, axi.w_data, axi.w_strb, axi.w_last} !== {1'b1, e}) begin
        n_err++; $display("FAIL line_write_beat b%0d got v%b d%h s%h l%b want v1 %h",
                          b, axi.w_valid, axi.w_data, axi.w_strb, axi.w_last, e);
      end
      @(negedge clock);
      axi.w_ready = 1'b0;
    end
    n_cmp++;
    if ({axi.w_valid, resp_valid} !== 2'b01) begin
      n_err++; $display("FAIL line_write_done got %b want 01", {axi.w_valid, resp_valid});
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    wait_idle();
  endtask

  task automatic test_early_last();
    logic [LINE_W-1:0] e;
    logic ee;
    exp_rd_q.push_back({64'h0, 64'h3333_3333_3333_3333});
    exp_err_q.push_back(1'b1);
    send_req(1'b0, 1'b1, 64'h8000_0040, 3'd0, '0, 8'h00);
    @(negedge clock);
    axi.r_valid = 1'b1; axi.r_data = 64'h3333_3333_3333_3333; axi.r_last = 1'b1;
    @(negedge clock);
    axi.r_valid = 1'b0; axi.r_last = 1'b0;
    e = exp_rd_q.pop_front(); ee = exp_err_q.pop_front();
    n_cmp++;
    if ({resp_valid, resp_rdata, resp_err} !== {1'b1, e, ee}) begin
      n_err++; $display("FAIL early_last got v%b d%h e%b want v1 d%h e%b",
                        resp_valid, resp_rdata, resp_err, e, ee);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    wait_idle();
  endtask

  task automatic test_back_pressure();
    logic [LINE_W-1:0] e;
    logic ee;
    exp_rd_q.push_back({64'h0, 64'hCAFE_F00D_1234_5678});
    exp_err_q.push_back(1'b0);
    send_req(1'b0, 1'b0, 64'h8000_0104, 3'd2, '0, 8'h00);
    n_cmp++;
    if ({axi.ar_valid, axi.ar_addr, axi.ar_len, axi.ar_size} !== {1'b1, 64'h8000_0104, 8'd0, 3'd2}) begin
      n_err++; $display("FAIL single_read_ar got v%b a%h l%0d s%0d want v1 a8000_0104 l0 s2",
                        axi.ar_valid, axi.ar_addr, axi.ar_len, axi.ar_size);
    end
    @(negedge clock);
    axi.r_valid = 1'b1; axi.r_data = 64'hCAFE_F00D_1234_5678; axi.r_last = 1'b1;
    @(negedge clock);
    axi.r_valid = 1'b0; axi.r_last = 1'b0;
    req_addr = 64'h9000_0000; req_wen = 1'b0; req_valid = 1'b1;
    e = exp_rd_q.pop_front(); ee = exp_err_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({resp_valid, req_ready, axi.ar_valid, resp_rdata, resp_err} !== {3'b100, e, ee}) begin
        n_err++; $display("FAIL back_pressure c%0d got rv%b rq%b ar%b d%h e%b want rv1 rq0 ar0 d%h e%b",
                          k, resp_valid, req_ready, axi.ar_valid, resp_rdata, resp_err, e, ee);
      end
      @(negedge clock);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    n_cmp++;
    if ({req_ready, resp_valid, axi.ar_valid} !== 3'b100) begin
      n_err++; $display("FAIL back_pressure_release got %b want 100", {req_ready, resp_valid, axi.ar_valid});
    end
    wait_idle();
  endtask

  task automatic test_reset_mid_read();
    logic [LINE_W-1:0] e;
    logic ee;
    send_req(1'b0, 1'b1, 64'h8000_0080, 3'd0, '0, 8'h00);
    @(negedge clock);
    axi.r_valid = 1'b1; axi.r_data = 64'h7777_7777_7777_7777; axi.r_last = 1'b0;
    @(negedge clock);
    axi.r_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_cmp++;
    if ({axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, resp_valid, req_ready} !== 6'b000001) begin
      n_err++; $display("FAIL reset_mid_state got %b want 000001",
                        {axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, resp_valid, req_ready});
    end
    n_cmp++;
    if (resp_rdata !== '0) begin
      n_err++; $display("FAIL reset_mid_buffer got %h want 0", resp_rdata);
    end
    exp_rd_q.push_back({64'h5555_5555_5555_5555, 64'h4444_4444_4444_4444});
    exp_err_q.push_back(1'b0);
    send_req(1'b0, 1'b1, 64'h8000_00c0, 3'd0, '0, 8'h00);
    // beat offered while still in AR must be ignored
    axi.r_valid = 1'b1; axi.r_data = 64'hDEAD_DEAD_DEAD_DEAD; axi.r_last = 1'b1;
    @(negedge clock);
    axi.r_data = 64'h4444_4444_4444_4444; axi.r_last = 1'b0;
    @(negedge clock);
    axi.r_data = 64'h5555_5555_5555_5555; axi.r_last = 1'b1;
    @(negedge clock);
    axi.r_valid = 1'b0; axi.r_last = 1'b0;
    e = exp_rd_q.pop_front(); ee = exp_err_q.pop_front();
    n_cmp++;
    if ({resp_valid, resp_rdata, resp_err} !== {1'b1, e, ee}) begin
      n_err++; $display("FAIL reset_mid_rerun got v%b d%h e%b want v1 d%h e%b",
                        resp_valid, resp_rdata, resp_err, e, ee);
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    wait_idle();
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_line = 1'b0; req_addr = '0;
    req_size = '0; req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
    axi.ar_ready = 1'b1; axi.aw_ready = 1'b1; axi.w_ready = 1'b0;
    axi.r_valid = 1'b0; axi.r_data = '0; axi.r_last = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_line_read();
    test_single_write();
    test_line_write_stall();
    test_early_last();
    test_back_pressure();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22050550_axi_burst_master.md
# ysyx_22050550_axi_burst_master

AXI4-style read/write initiator between the cache/LSU and the memory-side responder. It converts one cache request into an INCR burst on the AR/R or AW/W channels: either a full line fill/writeback of `BEATS` 64-bit beats, or a single uncached beat. It buffers the line and returns it to the requester with a valid/ready response. There is no B channel. A write is complete when its last W beat is accepted.

## Interface
Parameters:
- `BEATS`, default 2: 64-bit beats per cache line, 1..16.
- `LINE_W`, default 64*BEATS: line width in bits, derived.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req_valid` / `req_ready`  in/out  1  request handshake.
- `req_wen`  in  1  1 = write, 0 = read.
- `req_line`  in  1  1 = line burst (len BEATS-1, size 3'b011), 0 = single beat.
- `req_addr`  in  64  start address, passed unmodified.
- `req_size`  in  3  AXI size for single beats; ignored for line bursts.
- `req_wdata`  in  LINE_W  write line, beat i = bits [64i+63:64i].
- `req_wstrb`  in  8  strobe for single writes; line writes use 8'hFF.
- `resp_valid` / `resp_ready`  out/in  1  completion handshake.
- `resp_rdata`  out  LINE_W  read line; single read returns the beat in slot 0 with upper slots zero.
- `resp_err`  out  1  beat count mismatch (early/late r_last).
- `ar_valid` out 1, `ar_ready` in 1, `ar_addr` out 64, `ar_len` out 8, `ar_size` out 3, `ar_burst` out 2.
- `r_valid` in 1, `r_ready` out 1, `r_data` in 64, `r_last` in 1.
- `aw_valid` out 1, `aw_ready` in 1, `aw_addr` out 64, `aw_len` out 8, `aw_size` out 3, `aw_burst` out 2.
- `w_valid` out 1, `w_ready` in 1, `w_data` out 64, `w_strb` out 8, `w_last` out 1.

## Operation
States: `IDLE`, `AR`, `R`, `AW`, `W`, `RESP`.
- **IDLE:** `req_ready`=1. On `req_valid`: latch addr, wen, line, size, wdata, wstrb. Clear the beat counter and err. Go to `AW` if wen, else `AR`.
- **AR:** `ar_valid`=1 and address fields held stable. On `ar_ready`, go to `R`.
- **R:** `r_ready`=1.
  - Each `r_valid` beat writes `r_data` into slot `cnt` and increments `cnt`. Writes with `cnt` ≥ BEATS are dropped.
  - Go to `RESP` on the beat with `r_last`=1.
  - `resp_err`=1 if the index of the beat carrying `r_last` ≠ len.
- **AW:** `aw_valid`=1. On `aw_ready`, go to `W`.
- **W:** `w_valid`=1, `w_data`=slot[cnt], `w_last`=(cnt==len). On `w_ready`, increment `cnt`. The last accepted beat goes to `RESP`.
- **RESP:** `resp_valid`=1, with `resp_rdata` and `resp_err` stable. On `resp_ready`, go to `IDLE`.

Field rules:
- len = req_line ? BEATS-1 : 0, 8 bits.
- size = req_line ? 3'b011 : req_size.
- burst is always 2'b01 (INCR).
- `cnt` is 4 bits wide and never wraps within a transaction.

Reset mid-operation: the state returns to `IDLE`, all valids/readies drop, and the buffer and `cnt` clear. The transaction is abandoned and no response is issued.

## Timing
- Reset values: `req_ready`=1. `ar_valid`, `aw_valid`, `w_valid`, `r_ready`, `resp_valid`, `resp_err`, `w_last` are 0. All data/addr outputs are 0. `ar_burst`/`aw_burst` = 2'b01.
- A request accepted at cycle N drives `ar_valid`/`aw_valid` from N+1.
- Valids stay asserted until their handshake. No combinational path from any `*_ready` input to any `*_valid` output.
- With a zero-wait responder:
  - A line read of BEATS=2 raises `resp_valid` at N+4: AR at N+1, beats at N+2 and N+3.
  - A single read raises `resp_valid` at N+3.
- `req_ready` is 0 from N+1 until the cycle after the `resp_valid`&&`resp_ready` handshake. Only one transaction is outstanding.
- `r_valid` outside `R` and `w_ready` outside `W` are ignored.

## Structure
- Shared package:
  - state encoding;
  - AXI constants `BURST_INCR`=2'b01 and `SIZE_8B`=3'b011;
  - the derived `LINE_W`.
- One sub-module, `ysyx_22050550_axi_line_buf`: a BEATS×64 register slot array with a per-beat write enable, parallel load from `req_wdata`, indexed beat read, and clear.

## Test plan
- **Line read, BEATS=2, zero-wait responder.**
  - Stimulus: req addr 0x8000_0010, r_data 0x1111…, 0x2222….
  - Required: `ar_len`=1, `ar_size`=3, `ar_burst`=1. `resp_rdata`={0x2222…,0x1111…} at N+4, `resp_err`=0.
- **Single write.**
  - Stimulus: addr 0xa000_03f8, size 0, wstrb 8'h01, wdata 0x5A.
  - Required: `aw_len`=0, one W beat with `w_strb`=8'h01 and `w_last`=1, then `resp_valid`.
- **Line writeback with `w_ready` stalled 3 cycles per beat.**
  - Required: `w_data` stays stable during each stall; beat order is slot 0 then slot 1.
- **Early `r_last` on beat 0 of a BEATS=2 read.**
  - Required: go to `RESP` with `resp_err`=1 and slot 1 = 0.
- **Back-pressure.**
  - Stimulus: hold `resp_ready`=0 for 5 cycles.
  - Required: `resp_valid` and data held, `req_ready`=0, and no new AR issued.
- **Reset asserted during `R` after 1 beat.**
  - Required: next cycle is `IDLE` with all valids 0. A new request then completes normally.
